// File: rtl/load_unit_fsm_if.sv
// Load unit handshake bundle: request, data-memory read and response channels.
// slave is the load unit's view, master is the surrounding pipeline/memory.
interface load_unit_fsm_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [4:0]        req_rd;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_data;
  logic [4:0]        resp_rd;
  logic              resp_err;
  logic              resp_misaligned;

  modport slave (
    input  req_valid,
    input  req_funct3,
    input  req_addr,
    input  req_rd,
    input  mem_rvalid,
    input  mem_rdata,
    input  resp_ready,
    output req_ready,
    output mem_rd_en,
    output mem_addr,
    output resp_valid,
    output resp_data,
    output resp_rd,
    output resp_err,
    output resp_misaligned
  );

  modport master (
    output req_valid,
    output req_funct3,
    output req_addr,
    output req_rd,
    output mem_rvalid,
    output mem_rdata,
    output resp_ready,
    input  req_ready,
    input  mem_rd_en,
    input  mem_addr,
    input  resp_valid,
    input  resp_data,
    input  resp_rd,
    input  resp_err,
    input  resp_misaligned
  );
endinterface

// File: rtl/load_unit_fsm.sv
// Sequential RISC-V load unit: aligned word read, lane extract, sign/zero extend.
// LOAD_MISALIGN_TRAP_EN: trap misaligned accesses instead of forcing alignment.
module load_unit_fsm #(
  parameter int XLEN    = 64,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  load_unit_fsm_if.slave bus
);

  localparam int OW = $clog2(XLEN / 8);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e            state_q;
  logic              req_ready_q;
  logic              mem_rd_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              resp_valid_q;
  logic [XLEN-1:0]   resp_data_q;
  logic [4:0]        resp_rd_q;
  logic              resp_err_q;
  logic [2:0]        f3_q;
  logic [OW-1:0]     off_q;
  logic [CW-1:0]     cnt_q;

  logic [OW-1:0]     req_off;
  logic [OW-1:0]     off_d;
  logic [ADDR_W-1:0] addr_d;
  logic              illegal;

  logic [XLEN-1:0]   lane;
  logic [XLEN-1:0]   mask;
  logic [XLEN-1:0]   res_d;
  logic [6:0]        bits;
  logic              msb;
  logic              sgn;

  assign illegal = (bus.req_funct3 == 3'd7) ||
                   ((XLEN == 32) &&
                    ((bus.req_funct3 == 3'd3) ||
                     (bus.req_funct3 == 3'd6)));

  assign addr_d = {bus.req_addr[ADDR_W-1:OW], OW'(0)};

  // Offset rounded down to the natural alignment of the access size
  always_comb begin
    req_off = bus.req_addr[OW-1:0];
    off_d   = req_off;
    unique case (bus.req_funct3[1:0])
      2'd0:    off_d = req_off;
      2'd1:    off_d = req_off & ~OW'(1);
      2'd2:    off_d = req_off & ~OW'(3);
      default: off_d = '0;
    endcase
  end

`ifdef LOAD_MISALIGN_TRAP_EN
  logic misal;
  logic resp_misaligned_q;

  assign misal = (off_d != req_off);
  assign bus.resp_misaligned = resp_misaligned_q;
`else
  assign bus.resp_misaligned = 1'b0;
`endif

  always_comb begin
    lane = bus.mem_rdata >> {off_q, 3'b000};
    bits = 7'd8;
    msb  = 1'b0;
    sgn  = 1'b0;
    unique case (f3_q)
      3'd0: begin
        bits = 7'd8;
        msb  = lane[7];
        sgn  = 1'b1;
      end
      3'd1: begin
        bits = 7'd16;
        msb  = lane[15];
        sgn  = 1'b1;
      end
      3'd2: begin
        bits = 7'd32;
        msb  = lane[31];
        sgn  = 1'b1;
      end
      3'd4: bits = 7'd8;
      3'd5: bits = 7'd16;
      3'd6: bits = 7'd32;
      default: bits = 7'(XLEN);
    endcase
    // Shifting by XLEN yields an all-ones mask for full-width loads
    mask  = ~({XLEN{1'b1}} << bits);
    res_d = (lane & mask) | ((sgn && msb) ? ~mask : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
      resp_err_q   <= 1'b0;
      f3_q         <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
`ifdef LOAD_MISALIGN_TRAP_EN
      resp_misaligned_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            f3_q        <= bus.req_funct3;
            off_q       <= off_d;
            resp_rd_q   <= bus.req_rd;
            req_ready_q <= 1'b0;
            cnt_q       <= '0;
            resp_err_q  <= 1'b0;
            resp_data_q <= '0;
`ifdef LOAD_MISALIGN_TRAP_EN
            resp_misaligned_q <= 1'b0;
`endif
            if (illegal) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end
`ifdef LOAD_MISALIGN_TRAP_EN
            else if (misal) begin
              state_q           <= RESP;
              resp_valid_q      <= 1'b1;
              resp_err_q        <= 1'b1;
              resp_misaligned_q <= 1'b1;
            end
`endif
            else begin
              state_q     <= ISSUE;
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= addr_d;
            end
          end
        end
        ISSUE: begin
          state_q     <= WAIT;
          mem_rd_en_q <= 1'b0;
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_data_q  <= res_d;
            resp_err_q   <= 1'b0;
            cnt_q        <= '0;
          end else if ((TIMEOUT > 0) &&
                       (32'(cnt_q) == TIMEOUT - 1)) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.mem_rd_en  = mem_rd_en_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_rd    = resp_rd_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: doc/load_unit_fsm.md
Name: load_unit_fsm

Overview:
- Parametrised, sequential successor to the combinational load extender.
- Accepts one RISC-V load request (funct3, address, destination tag) and issues an aligned word read to data memory.
- Waits for the read data, extracts the addressed byte lane, and applies correct sign or zero extension.
- Returns the result on a valid/ready response channel, with error reporting for illegal funct3, memory timeout and (optionally) misalignment.

Parameters:
- XLEN, 64: data width; 32 or 64 only.
- ADDR_W, 64: address width.
- TIMEOUT, 16: cycles to wait for mem_rvalid before an error response; 0 disables the watchdog.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit can accept a request.
- req_funct3  in  3  load type, instr[14:12].
- req_addr  in  ADDR_W  effective byte address.
- req_rd  in  5  destination register tag.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_addr  out  ADDR_W  req_addr with low log2(XLEN/8) bits cleared.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read data.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  XLEN  extended load result.
- resp_rd  out  5  tag echoed from the request.
- resp_err  out  1  error response: illegal funct3, misaligned access, or timeout.
- resp_misaligned  out  1  misalignment cause; tied 0 without the macro.

Behaviour:
- Reset (synchronous, active-high): state IDLE. req_ready=1; mem_rd_en=0; mem_addr=0; resp_valid=0; resp_data=0; resp_rd=0; resp_err=0; resp_misaligned=0; timeout counter=0.
- Reset mid-operation aborts the load immediately and returns to IDLE. A late mem_rvalid after reset is ignored.
- State IDLE:
  - req_ready=1.
  - On req_valid, latch funct3, offset = addr[log2(XLEN/8)-1:0], and rd.
  - Illegal funct3 goes to RESP with err=1 and data 0. Illegal means 7 always, plus 3 (ld) and 6 (lwu) when XLEN=32.
  - Misaligned access (macro only) goes to RESP with err=1, misaligned=1, data 0.
  - Otherwise go to ISSUE.
- State ISSUE: mem_rd_en=1 for exactly one cycle with mem_addr driven; then go to WAIT.
- State WAIT:
  - mem_rvalid is sampled only in this state; it is ignored in IDLE, ISSUE and RESP.
  - On mem_rvalid, register the extracted result, clear the counter, and go to RESP.
  - If TIMEOUT>0 and the counter reaches TIMEOUT with no rvalid, go to RESP with err=1 and data 0.
  - The counter increments every WAIT cycle.
- State RESP:
  - resp_valid=1; resp_data, resp_rd and resp_err are held stable while resp_ready=0.
  - On resp_ready, go to IDLE; req_ready is 1 in the following cycle. No request overlap.
- Latency: request accepted in cycle N, strobe in N+1, rvalid in N+2 gives resp_valid in N+3. Back-to-back throughput is one load per 4 cycles minimum.
- Extraction: lane = mem_rdata >> (offset*8).
  - funct3 0 lb: sign-extend lane[7:0].
  - funct3 1 lh: sign-extend lane[15:0].
  - funct3 2 lw: sign-extend lane[31:0].
  - funct3 3 ld: full word.
  - funct3 4 lbu, 5 lhu, 6 lwu: zero-extend 8, 16 and 32 bits respectively.
  - Sign extension replicates the MSB across all upper bits, never a single 1 bit.

Optional Feature:
- Macro LOAD_MISALIGN_TRAP_EN.
- Defined:
  - lh with offset[0]!=0, lw with offset[1:0]!=0, or ld with offset!=0 is misaligned.
  - A misaligned request never asserts mem_rd_en; it responds with resp_err=1, resp_misaligned=1, resp_data=0 in cycle N+1.
- Undefined:
  - The offset is forced to natural alignment, offset & ~(size-1), and the access proceeds normally.
  - resp_misaligned is tied to 0.

Test Plan:
- XLEN=64, lb, addr 0x1003, rdata 0xF0E0D0C0B0A09080, rvalid at N+2 -> mem_addr 0x1000; resp_data 0xFFFFFFFFFFFFFFB0 at N+3; err 0.
- lbu addr 0x1003 -> 0x00000000000000B0. lhu addr 0x1006 -> 0x000000000000F0E0. lw addr 0x1004 -> 0xFFFFFFFFF0E0D0C0. ld addr 0x1000 -> 0xF0E0D0C0B0A09080.
- funct3=7 -> no mem_rd_en; resp_err=1 and resp_data=0 at N+1. With XLEN=32, funct3=3 -> same response.
- With macro, lw addr 0x1002 -> no strobe; err=1, misaligned=1. Without macro, same request -> offset 0, resp_data 0xFFFFFFFFB0A09080.
- TIMEOUT=16, mem_rvalid never asserted -> resp_err=1 after 16 WAIT cycles. A late rvalid then arriving in IDLE is ignored.
- resp_ready held 0 for 5 cycles -> resp_data and resp_rd stable, req_ready 0 throughout. Reset asserted in WAIT -> IDLE next cycle, resp_valid 0.
